trigger_event_buffer: RTL
=========================

Name: trigger_event_buffer

Overview:
- Sits directly downstream of the edge trigger handler, on the fast clock domain.
- Converts each rising edge of the trigger output into a timestamped event word: free-running timestamp plus a channel-hit snapshot of both signal lines.
- Buffers event words in a small FIFO so the ESP32 readout path can drain them at its own pace.
- Applies a configurable dead time after each accepted trigger and counts events lost to a full buffer.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 words).
- TS_WIDTH, 30, timestamp width; event word width is TS_WIDTH+2.

Ports:
- CLK  in  1  fast clock (same as edge trigger handler).
- RESET  in  1  synchronous, active-high reset.
- TRIGGER_IN  in  1  trigger output of the edge trigger handler; level, may stay high for several cycles.
- SIGNAL1  in  1  conditioned signal line 1 (same net that feeds the trigger handler).
- SIGNAL2  in  1  conditioned signal line 2.
- read_mode  in  1  1 = readout in progress; capture of new events is inhibited.
- mconfig  in  16  [0] capture enable; [1] clear drop counter (level); [3:2] reserved, ignored; [11:4] dead time in CLK cycles; [15:12] reserved, ignored.
- RD_EN  in  1  pop request from the readout logic.
- RD_DATA  out  TS_WIDTH+2  popped event: [TS_WIDTH+1] SIGNAL2 hit, [TS_WIDTH] SIGNAL1 hit, [TS_WIDTH-1:0] timestamp.
- RD_VALID  out  1  one-cycle strobe; RD_DATA is valid while this is high.
- FIFO_COUNT  out  DEPTH_LOG2+1  number of stored words.
- FIFO_EMPTY  out  1  FIFO_COUNT == 0.
- FIFO_FULL  out  1  FIFO_COUNT == 2^DEPTH_LOG2.
- DROP_COUNT  out  16  triggers lost because the FIFO was full; saturates at 0xFFFF.

Behaviour:
- Reset values: RD_DATA=0, RD_VALID=0, FIFO_COUNT=0, FIFO_EMPTY=1, FIFO_FULL=0, DROP_COUNT=0, timestamp=0, FSM=IDLE. All FIFO pointers are cleared.
- Reset mid-operation discards all stored events on the next clock edge.
- Timestamp counter:
  - Increments every cycle and wraps from 2^TS_WIDTH-1 to 0 without a flag.
  - Runs regardless of mconfig and read_mode.
- Edge detect:
  - TRIGGER_IN is registered once (t_d).
  - A trigger edge is TRIGGER_IN && !t_d.
  - A level held high produces exactly one edge.
- Capture snapshot at the edge cycle:
  - Timestamp value in that cycle.
  - SIGNAL1 and SIGNAL2 sampled in that same cycle.
- Capture FSM states:
  - IDLE: an edge with mconfig[0]=1 and read_mode=0 is an accepted trigger. If mconfig[11:4] != 0, go to DEAD with dead counter = mconfig[11:4]. If dead time is 0, stay in IDLE.
  - DEAD: decrement the counter each cycle; return to IDLE when it reaches 1. Edges arriving in DEAD are ignored, are not counted as drops, and do not restart the counter.
  - An edge arriving with mconfig[0]=0 or read_mode=1 is ignored and does not enter DEAD.
- Push, on an accepted trigger:
  - The word is written in the edge cycle; FIFO_COUNT updates on the following edge.
  - If the FIFO is full and there is no pop in the same cycle: the word is dropped and DROP_COUNT increments (saturating). The FSM still enters DEAD.
- Pop:
  - RD_EN=1 with FIFO_EMPTY=0 pops the oldest word.
  - RD_DATA is updated and RD_VALID=1 on the next cycle; RD_VALID lasts exactly one cycle per pop.
  - RD_EN while empty is ignored: RD_VALID stays 0 and RD_DATA holds its last value.
- Simultaneous push and pop:
  - Both are performed, including when the FIFO is full; FIFO_COUNT is unchanged.
  - When empty, a simultaneous push and pop does not bypass: only the push happens and RD_VALID stays 0.
- Pointers: binary, wrapping modulo depth. Ordering is strict FIFO.
- mconfig[1]=1:
  - Holds DROP_COUNT at 0; it takes priority over a simultaneous drop increment.
  - Does not affect FIFO contents.
- Reserved mconfig bits are ignored. Changing mconfig[11:4] while in DEAD does not affect the dead window already in progress.

Test Plan:
- Single event: after reset, mconfig=0x0001; TRIGGER_IN pulses high for 3 cycles at timestamp 20 with SIGNAL1=1, SIGNAL2=0 -> FIFO_COUNT=1; RD_EN pulse -> RD_VALID for 1 cycle, RD_DATA = {2'b01, 30'd20}.
- Dead time: mconfig=0x0051 (dead time 5); edges at timestamps 10, 13, 16 -> exactly two words stored, timestamps 10 and 16; DROP_COUNT=0.
- Overflow: mconfig=0x0011 (dead time 1); 20 edges spaced 4 cycles apart, no reads -> FIFO_FULL=1, FIFO_COUNT=16, DROP_COUNT=4; the 16 words drained in order carry the first 16 timestamps.
- Full with simultaneous push and pop: FIFO full; a pop and an accepted edge in the same cycle -> FIFO_COUNT stays 16, DROP_COUNT unchanged, new word is last out.
- Inhibit: read_mode=1, or mconfig[0]=0, during 3 edges -> no words, no drops, FSM stays IDLE; RD_EN while empty -> RD_VALID stays 0.
- Reset and clear: reset asserted with 5 words stored -> next cycle FIFO_EMPTY=1, DROP_COUNT=0, timestamp restarts at 0. Separately, mconfig[1]=1 with DROP_COUNT=4 -> DROP_COUNT=0 on the next cycle.

Source files
------------

// File: rtl/trigger_event_buffer.sv
// trigger_event_buffer
// Turns each rising edge of the trigger handler output into a timestamped
// event word {SIGNAL2 hit, SIGNAL1 hit, timestamp}. Event words are queued in a
// small FIFO that the readout side drains at its own pace. After each accepted
// trigger, a programmable dead window blocks new triggers. Triggers that arrive
// while the FIFO is full are counted as drops.
//
// Readout handshake: RD_EN is a request. It pops only when FIFO_EMPTY=0. A pop
// presents the oldest word on RD_DATA in the following cycle, with RD_VALID high
// for exactly that one cycle. The readout side has no backpressure. RD_EN on an
// empty FIFO is ignored, and RD_DATA keeps its last value.
module trigger_event_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_WIDTH   = 30
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TRIGGER_IN,
    input  logic                    SIGNAL1,
    input  logic                    SIGNAL2,
    input  logic                    read_mode,
    input  logic [15:0]             mconfig,
    input  logic                    RD_EN,
    output logic [TS_WIDTH+1:0]     RD_DATA,
    output logic                    RD_VALID,
    output logic [DEPTH_LOG2:0]     FIFO_COUNT,
    output logic                    FIFO_EMPTY,
    output logic                    FIFO_FULL,
    output logic [15:0]             DROP_COUNT,
    output logic [1:0]              o_dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_ONE  = (DEPTH_LOG2+1)'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEAD = 2'd1;

    logic [TS_WIDTH-1:0]   r_ts;
    logic                  r_t_d;
    logic [1:0]            r_state;
    logic [7:0]            r_dead_cnt;
    logic [TS_WIDTH+1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [15:0]           r_drop;
    logic [TS_WIDTH+1:0]   r_rd_data;
    logic                  r_rd_valid;

    logic                  w_edge;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [7:0]            w_dead_time;
    logic [TS_WIDTH+1:0]   w_word;
    logic                  w_unused_cfg;

    assign w_full       = (r_count == C_FULL);
    assign w_empty      = (r_count == '0);
    assign w_edge       = TRIGGER_IN & ~r_t_d;
    assign w_dead_time  = mconfig[11:4];
    assign w_accept     = w_edge & mconfig[0] & ~read_mode & (r_state == ST_IDLE);
    assign w_pop        = RD_EN & ~w_empty;
    // A full FIFO still takes the new word if a pop frees a slot in the same cycle.
    assign w_push       = w_accept & (~w_full | w_pop);
    assign w_drop       = w_accept & w_full & ~w_pop;
    assign w_word       = {SIGNAL2, SIGNAL1, r_ts};
    assign w_unused_cfg = ^{mconfig[15:12], mconfig[3:2]};

    // Free-running timestamp plus the one-cycle delayed trigger used for edge detect.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ts  <= '0;
            r_t_d <= 1'b0;
        end else begin
            r_ts  <= r_ts + TS_WIDTH'(1);
            r_t_d <= TRIGGER_IN;
        end
    end

    // Capture FSM: an accepted trigger opens a dead window of mconfig[11:4] cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_dead_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_dead_time != 8'd0)) begin
                        r_state    <= ST_DEAD;
                        r_dead_cnt <= w_dead_time;
                    end
                end
                ST_DEAD: begin
                    if (r_dead_cnt <= 8'd1) begin
                        r_state    <= ST_IDLE;
                        r_dead_cnt <= '0;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dead_cnt <= '0;
                end
            endcase
        end
    end

    // Event storage. The array has no reset; only the pointers define its contents.
    always_ff @(posedge CLK) begin
        if (!RESET && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers and occupancy. An empty FIFO never bypasses a push straight to a pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_ONE;
            end
        end
    end

    // Read port: one-cycle valid strobe per pop, and data held between pops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Drop counter: saturating, and the clear level wins over a same-cycle drop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_drop <= '0;
        end else if (mconfig[1]) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign RD_DATA     = r_rd_data;
    assign RD_VALID    = r_rd_valid;
    assign FIFO_COUNT  = r_count;
    assign FIFO_EMPTY  = w_empty;
    assign FIFO_FULL   = w_full;
    assign DROP_COUNT  = r_drop;
    assign o_dbg_state = r_state;

endmodule
